// File: rtl/pjesetuesi_16b.sv
// Sequential unsigned restoring divider: one quotient bit per clock by trial subtraction.
// Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
module pjesetuesi_16b #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HERESI,
    output logic [WIDTH-1:0] MBETJA,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        // Remainder stays below the divisor, so the shifted value needs one extra bit.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (B == '0) begin
                        quo_d   = '1;
                        rem_d   = A;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        quo_d   = A;
                        dvs_d   = B;
                        rem_d   = '0;
                        cnt_d   = CntW'(WIDTH);
                        dz_d    = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign HERESI   = quo_q;
    assign MBETJA   = rem_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_pjesetuesi_16b.sv
// Self-checking bench for pjesetuesi_16b: directed cases plus a randomized regression
// against a cycle-level behavioural model built from plain A/B and A%B arithmetic.
module tb_pjesetuesi_16b;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          busy, done, div_zero;
    logic [W-1:0]  HERESI, MBETJA;

    int checks = 0;
    int failures = 0;

    pjesetuesi_16b #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .HERESI   (HERESI),
        .MBETJA   (MBETJA),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a countdown of remaining busy cycles plus final results from / and %.
    int           left = 0;
    bit           m_busy = 0, m_done = 0, m_dz = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    int           exp_done = 0;
    int           dut_done = 0;
    bit           chk_en = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            left = 0; m_busy = 0; m_done = 0; m_dz = 0; m_q = '0; m_r = '0;
        end else if (left > 0) begin
            left--;
            if (left == 0) begin
                m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; exp_done++;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            if (B == '0) begin
                m_done = 1; m_q = '1; m_r = A; m_dz = 1; exp_done++;
            end else begin
                left = W; m_busy = 1; m_dz = 0; p_q = A / B; p_r = A % B;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("div_zero", div_zero, m_dz);
            if (!m_busy) begin
                chk("quotient", HERESI, m_q);
                chk("remainder", MBETJA, m_r);
            end
            if (done) dut_done++;
        end
    end

    task automatic wait_done(output bit ok, output int nbusy);
        ok = 0;
        nbusy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk("done_within_bound", ok, 1);
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input bit edz, input bit lit);
        bit ok;
        int nb;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; A = 16'($urandom); B = 16'($urandom);
        wait_done(ok, nb);
        if (lit && ok) begin
            chk("lit_quotient", HERESI, eq);
            chk("lit_remainder", MBETJA, er);
            chk("lit_div_zero", div_zero, edz);
            chk("lit_busy_cycles", nb, (b == '0) ? 0 : W);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("hold_quotient", HERESI, eq);
                chk("hold_remainder", MBETJA, er);
                chk("hold_done_low", done, 0);
            end
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int nb;
        int seen;
        logic [W-1:0] ra, rb;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", HERESI, 0);
        chk("rst_remainder", MBETJA, 0);
        chk("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        chk_en = 1;

        do_div(16'd100, 16'd7, 16'd14, 16'd2, 0, 1);
        do_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 0, 1);
        do_div(16'd3, 16'd10, 16'd0, 16'd3, 0, 1);
        do_div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 0, 1);
        do_div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1, 1);
        do_div(16'd100, 16'd7, 16'd14, 16'd2, 0, 1);

        // Starts during RUN and on the done cycle are ignored
        @(negedge clk);
        A = 16'd100; B = 16'd7; start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 17) begin
                chk("ign_done", done, 1);
                chk("ign_quotient", HERESI, 14);
                chk("ign_remainder", MBETJA, 2);
            end
            start = (k == 3 || k == 16 || k == 17);
            A = 16'd50; B = 16'd5;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(ok, nb);
        chk("edge18_quotient", HERESI, 10);
        chk("edge18_remainder", MBETJA, 0);
        chk("edge18_busy_cycles", nb, W);
        @(negedge clk);

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        A = 16'd1000; B = 16'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", HERESI, 0);
        chk("abort_remainder", MBETJA, 0);
        chk("abort_div_zero", div_zero, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        do_div(16'd1000, 16'd3, 16'd333, 16'd1, 0, 1);

        // Random regression
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            ra = 16'($urandom);
            if (r < 8) rb = '0;
            else if (r < 40) rb = 16'($urandom_range(1, 255));
            else rb = 16'($urandom);
            do_div(ra, rb, '0, '0, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("done_count", dut_done, exp_done);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
